// File: rtl/uart_pkg.sv
// ============================================================================
//  uart_pkg
//  Shared FSM state type, CRC-16/CCITT-FALSE constants and byte-wise update.
//  Optional feature macro: UART_FRAME_TX_PARITY_EN (adds one even-parity bit).
//  Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SEND   = 3'd2,
        CRC_HI = 3'd3,
        CRC_LO = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

`ifdef UART_FRAME_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // MSB-first, unreflected: one full byte folded into the register at once.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
//  uart_tx_serializer
//  Sends one UART character per load: start, 8 data bits LSB first, optional
//  even parity (UART_FRAME_TX_PARITY_EN), STOP_BITS stop bits.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       active_o,
    output logic       char_done_o
);

    localparam int NBITS = 9 + PARITY_BITS + STOP_BITS;
    localparam int SH_W  = NBITS - 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(NBITS - 1);

    logic             tx_q;
    logic             active_q;
    logic [SH_W-1:0]  shift_q;
    logic [3:0]       bit_q;
    logic [DIV_W-1:0] div_q;
    logic [SH_W-1:0]  shift_d;

    // Everything that follows the start bit, in line order from bit 0 upward.
`ifdef UART_FRAME_TX_PARITY_EN
    assign shift_d = {{STOP_BITS{1'b1}}, ^byte_i, byte_i};
`else
    assign shift_d = {{STOP_BITS{1'b1}}, byte_i};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            shift_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
        end else if (load_i) begin
            tx_q     <= 1'b0;
            active_q <= 1'b1;
            shift_q  <= shift_d;
            bit_q    <= '0;
            div_q    <= '0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (bit_q == BIT_LAST) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                    bit_q    <= '0;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b0, shift_q[SH_W-1:1]};
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign tx_o        = tx_q;
    assign active_o    = active_q;
    assign char_done_o = active_q && (div_q == DIV_LAST) && (bit_q == BIT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_frame_tx.sv
// ============================================================================
//  uart_frame_tx
//  Frames PAYLOAD_BYTES bytes plus CRC-16/CCITT-FALSE (high, low) onto a UART
//  line. Optional parity via macro UART_FRAME_TX_PARITY_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 16,
    parameter int CLK_DIV       = 434,
    parameter int STOP_BITS     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] crc_out
);

    localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES);

    state_t           state_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             frame_done_q;
    logic [15:0]      crc_q;
    logic [15:0]      crc_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      crc_d;

    logic       w_accept;
    logic       w_load;
    logic       w_ser_active;
    logic       w_char_done;
    logic [7:0] w_byte;

    assign w_accept = (state_q == FETCH) && in_valid && in_ready_q;
    assign crc_d    = crc16_byte(crc_q, in_data);

    // CRC characters load on the first cycle of their state, which doubles as their fetch cycle.
    assign w_load = w_accept ||
                    (((state_q == CRC_HI) || (state_q == CRC_LO)) && !w_ser_active);

    always_comb begin
        w_byte = in_data;
        if (state_q == CRC_HI) begin
            w_byte = crc_q[15:8];
        end else if (state_q == CRC_LO) begin
            w_byte = crc_q[7:0];
        end
    end

    uart_tx_serializer #(
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (STOP_BITS)
    ) u_ser (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (w_load),
        .byte_i      (w_byte),
        .tx_o        (tx_out),
        .active_o    (w_ser_active),
        .char_done_o (w_char_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            crc_q        <= CRC_INIT;
            crc_out_q    <= 16'h0000;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    if (start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        crc_q      <= CRC_INIT;
                        cnt_q      <= '0;
                    end
                end
                FETCH: begin
                    if (w_accept) begin
                        state_q    <= SEND;
                        in_ready_q <= 1'b0;
                        crc_q      <= crc_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (w_char_done) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= CRC_HI;
                        end else begin
                            state_q    <= FETCH;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                CRC_HI: begin
                    if (w_char_done) begin
                        state_q <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (w_char_done) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                        crc_out_q    <= crc_q;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign crc_out    = crc_out_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
// ============================================================================
//  tb_uart_frame_tx
//  Self-checking bench for uart_frame_tx (PAYLOAD_BYTES=9, CLK_DIV=4).
//  Honours macro UART_FRAME_TX_PARITY_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_tx;

    localparam int PB     = 9;
    localparam int DIV    = 4;
    localparam int SB     = 1;
`ifdef UART_FRAME_TX_PARITY_EN
    localparam int P      = 1;
`else
    localparam int P      = 0;
`endif
    localparam int NB     = 9 + P + SB;
    localparam int BUDGET = 2000;

    typedef struct {
        logic [PB*8-1:0] pl;
        int              gap_after;
        int              gap_len;
        bit              mid_start;
        bit              chk_pattern;
        logic [15:0]     exp_crc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx_out;
    logic        busy;
    logic        frame_done;
    logic [15:0] crc_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_count = 0;

    logic [11:0] rx_bits[$];
    bit          rx_stable[$];

    uart_frame_tx #(
        .PAYLOAD_BYTES (PB),
        .CLK_DIV       (DIV),
        .STOP_BITS     (SB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .crc_out    (crc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

    // Line receiver: records every character's bits and whether each bit held steady.
    logic [11:0] r_bits;
    bit          r_stable;
    bit          r_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx_out === 1'b0) begin
                r_bits = '1;
                r_stable = 1'b1;
                r_abort = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < DIV; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset !== 1'b1) r_abort = 1'b1;
                        if (c == 0) r_bits[b] = tx_out;
                        else if (tx_out !== r_bits[b]) r_stable = 1'b0;
                    end
                end
                if (!r_abort) begin
                    rx_bits.push_back(r_bits);
                    rx_stable.push_back(r_stable);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC by polynomial long division of the augmented message.
    function automatic logic [15:0] ref_crc(input logic [PB*8-1:0] pl);
        bit          m[$];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        for (int k = 0; k < PB; k++)
            for (int i = 7; i >= 0; i--) m.push_back(pl[k*8+i]);
        for (int j = 0; j < 16; j++) m[j] = m[j] ^ 1'b1;
        for (int j = 0; j < 16; j++) m.push_back(1'b0);
        for (int i = 0; i < m.size() - 16; i++)
            if (m[i]) for (int k = 0; k < 17; k++) m[i+k] = m[i+k] ^ g[16-k];
        for (int j = 0; j < 16; j++) r[15-j] = m[m.size()-16+j];
        return r;
    endfunction

    function automatic logic [11:0] char_bits(input logic [7:0] b);
        logic [11:0] v;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1+i] = b[i];
`ifdef UART_FRAME_TX_PARITY_EN
        v[9] = ^b;
`endif
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit pat);
        int          n;
        int          mism;
        logic [11:0] eb;
        in_data = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_ready", in_ready, 1);
        @(negedge clk);
        chk("ready_drop", in_ready, 0);
        chk("start_bit", tx_out, 0);
        if (pat) begin
            eb = char_bits(b);
            for (int bt = 0; bt < NB; bt++) begin
                mism = 0;
                for (int c = 0; c < DIV; c++) begin
                    if (bt != 0 || c != 0) @(negedge clk);
                    if (tx_out !== eb[bt]) mism++;
                end
                chk($sformatf("pattern_bit%0d", bt), mism, 0);
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        int          c0;
        int          n;
        int          base_rx;
        int          base_fd;
        bit          gap_bad;
        logic [7:0]  eb;
        base_rx = rx_bits.size();
        base_fd = fd_count;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        for (int k = 0; k < PB; k++) begin
            if (v.gap_len > 0 && k == v.gap_after) begin
                in_valid = 1'b0;
                gap_bad = 1'b0;
                repeat (v.gap_len) begin
                    @(negedge clk);
                    if (in_ready === 1'b1 && tx_out !== 1'b1) gap_bad = 1'b1;
                end
                chk("gap_line_idle", gap_bad, 0);
            end
            send_byte(v.pl[k*8 +: 8], v.chk_pattern && k == 0);
            if (v.mid_start && k == 4) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", frame_done, 1);
        if (v.gap_len == 0) chk("frame_len", cyc - c0, (PB + 2) * (NB * DIV + 1) + 1);
        chk("crc_out", crc_out, v.exp_crc);
        @(negedge clk);
        chk("busy_fall", busy, 0);
        chk("done_width", frame_done, 0);
        repeat (3) @(negedge clk);
        chk("done_pulses", fd_count - base_fd, 1);
        chk("rx_count", rx_bits.size() - base_rx, PB + 2);
        for (int k = 0; k < PB + 2; k++) begin
            if (base_rx + k < rx_bits.size()) begin
                if (k < PB) eb = v.pl[k*8 +: 8];
                else if (k == PB) eb = v.exp_crc[15:8];
                else eb = v.exp_crc[7:0];
                chk($sformatf("char%0d", k), rx_bits[base_rx+k], char_bits(eb));
                chk($sformatf("char%0d_timing", k), rx_stable[base_rx+k], 1);
            end
        end
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   base;
    bit   idle_bad;

    initial begin
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < PB; k++) vecs[i].pl[k*8 +: 8] = 8'($urandom);
            vecs[i].gap_after = 0;
            vecs[i].gap_len = 0;
            vecs[i].mid_start = 1'b0;
            vecs[i].chk_pattern = 1'b0;
        end
        for (int k = 0; k < PB; k++) vecs[0].pl[k*8 +: 8] = 8'h31 + 8'(k);
        vecs[0].exp_crc = 16'h29B1;
        vecs[1].pl[7:0] = 8'h55;
        vecs[1].chk_pattern = 1'b1;
        vecs[2].pl = vecs[0].pl;
        vecs[2].gap_after = 3;
        vecs[2].gap_len = 100;
        vecs[2].exp_crc = 16'h29B1;
        vecs[3].mid_start = 1'b1;
        for (int i = 4; i < 8; i++) begin
            vecs[i].gap_after = $urandom_range(1, PB - 1);
            vecs[i].gap_len = $urandom_range(0, 15);
        end
        for (int i = 1; i < 8; i++) if (i != 2) vecs[i].exp_crc = ref_crc(vecs[i].pl);

        #1 reset = 1'b0;
        #2;
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_crc", crc_out, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Reset in the middle of the second byte's data bits.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        repeat (DIV * 3) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_tx", tx_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_crc", crc_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        idle_bad = 1'b0;
        repeat (2 * NB * DIV) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_out !== 1'b1 || in_ready !== 1'b0) idle_bad = 1'b1;
        end
        chk("no_resume", idle_bad, 0);
        run_frame(vecs[0]);
        rv = vecs[5];
        rv.gap_len = 0;
        run_frame(rv);

`ifdef UART_FRAME_TX_PARITY_EN
        rv = vecs[6];
        rv.gap_len = 0;
        rv.pl[7:0] = 8'h07;
        rv.pl[15:8] = 8'h03;
        rv.exp_crc = ref_crc(rv.pl);
        base = rx_bits.size();
        run_frame(rv);
        if (rx_bits.size() >= base + 2) begin
            chk("parity_07", rx_bits[base][9], 1);
            chk("parity_03", rx_bits[base+1][9], 0);
        end else begin
            chk("parity_chars", rx_bits.size() - base, PB + 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 16: payload bytes per frame, range 1..256.
REQ-002 SHALL have parameter CLK_DIV, default 434: clk cycles per UART bit, minimum 2.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per character, 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a frame.
REQ-007 SHALL have ports in_data input 8 bits and in_valid input 1 bit: the payload byte stream.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 SHALL have port tx_out, output, 1 bit: the UART line, idle high.
REQ-010 SHALL have ports busy output 1 bit and frame_done output 1 bit: frame in progress, and a one-cycle end-of-frame pulse.
REQ-011 SHALL have port crc_out, output, 16 bits: the CRC of the last completed frame.

Function
REQ-012 Frame SHALL be: PAYLOAD_BYTES payload bytes, then CRC high byte, then CRC low byte.
REQ-013 CRC SHALL be CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
REQ-014 CRC SHALL be updated byte-wise at each accepted payload byte; no extra latency is allowed.
REQ-015 Each character SHALL be sent as: start bit 0, 8 data bits LSB first, optional parity bit (REQ-029), then STOP_BITS stop bits of 1.
REQ-016 Each bit SHALL last exactly CLK_DIV clk cycles.
REQ-017 FSM states SHALL be IDLE, FETCH, SEND, CRC_HI, CRC_LO and DONE.
REQ-018 IDLE -> FETCH on start; busy SHALL rise the cycle after start.
REQ-019 FETCH: in_ready SHALL be 1; a byte is accepted when in_valid && in_ready.
- in_ready SHALL drop the cycle after acceptance.
- The start bit SHALL begin on the cycle after acceptance.
REQ-020 SEND -> FETCH after the last stop bit while payload bytes remain; otherwise SEND -> CRC_HI.
REQ-021 CRC_HI -> CRC_LO -> DONE, each after its character's last stop bit.
REQ-022 DONE SHALL last one cycle.
- frame_done = 1 and crc_out is updated in that cycle.
- The next cycle returns to IDLE with busy = 0.
REQ-023 When in_valid is low in FETCH, the block SHALL wait indefinitely with tx_out = 1; there is no timeout.
REQ-024 start while busy SHALL be ignored.
REQ-025 When in_valid is continuously high, frame length SHALL be (PAYLOAD_BYTES+2)*(9+P+STOP_BITS)*CLK_DIV cycles plus one fetch cycle per character, where P is 1 with parity enabled and 0 otherwise.
REQ-026 The payload byte counter SHALL be ceil(log2(PAYLOAD_BYTES+1)) bits wide and SHALL NOT wrap.
REQ-027 The bit-period counter SHALL be ceil(log2(CLK_DIV)) bits wide and SHALL reload on every bit boundary.

Reset
REQ-028 On reset low, asynchronously and including mid-character:
- state = IDLE
- tx_out = 1, in_ready = 0, busy = 0, frame_done = 0
- crc_out = 0x0000
- CRC accumulator = 0xFFFF, all counters = 0
- A partial frame SHALL be discarded and SHALL NOT resume after reset.

Configuration
REQ-029 With macro UART_FRAME_TX_PARITY_EN defined:
- an even-parity bit (XOR of the 8 data bits) SHALL be inserted after bit 7 of every character, including the CRC characters.
- Without the macro there is no parity bit and no parity logic.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, CRC_POLY = 16'h1021, CRC_INIT = 16'hFFFF, and a crc16_byte update function.
REQ-031 Character serialisation SHALL be a sub-module, uart_tx_serializer.
- Inputs: load, byte; output: char_done; it owns the bit counter and the CLK_DIV counter.
- uart_frame_tx owns the FSM and the CRC.

Verification
REQ-032 PAYLOAD_BYTES=9, CLK_DIV=4, payload "123456789" (0x31..0x39) -> CRC characters 0x29 then 0xB1 on the line, crc_out = 0x29B1, one frame_done pulse.
REQ-033 PAYLOAD_BYTES=1, CLK_DIV=4, byte 0x55, no parity -> tx_out pattern 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, followed by the two CRC characters.
REQ-034 in_valid low for 100 cycles between bytes 3 and 4 -> tx_out = 1 throughout the gap, and the CRC equals the no-gap run.
REQ-035 reset low in the middle of byte 2's data bits -> tx_out = 1 and busy = 0 immediately; a new start sends a complete frame correctly.
REQ-036 start pulsed mid-frame -> no effect; exactly one frame_done pulse.
REQ-037 UART_FRAME_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after bit 7; byte 0x03 -> parity bit 0.
